// File: rtl/twos_comp_word_sequencer_pkg.sv
// Shared state encoding, default width and counter sizing for the
// two's-complement word sequencer.
package twos_comp_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  localparam int DEFAULT_WIDTH = 8;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/twos_comp_word_sequencer_if.sv
// Word-level valid/ready bundle for the sequencer; the ovf wire only exists
// when TC_OVF_FLAG_EN is defined.
interface twos_comp_word_sequencer_if
  import twos_comp_pkg::*;
  #(parameter int WIDTH = DEFAULT_WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;
`ifdef TC_OVF_FLAG_EN
  logic             ovf;

  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data, busy, ovf);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data, busy, ovf);
`else
  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data, busy);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data, busy);
`endif

endinterface

// File: rtl/twos_comp_word_sequencer_serial_bit.sv
// Bit-serial two's-complement core: copies bits up to and including the
// first one, then inverts every later bit.
module serial_twos_comp_bit (
  input  logic t_clock,
  input  logic r_n,
  input  logic clr,
  input  logic x,
  output logic y
);

  logic seen_one_q;
  logic seen_one_d;

  always_comb begin
    seen_one_d = clr ? 1'b0 : (seen_one_q | x);
  end

  assign y = seen_one_q ? ~x : x;

  always_ff @(posedge t_clock or negedge r_n) begin
    if (!r_n) seen_one_q <= 1'b0;
    else      seen_one_q <= seen_one_d;
  end

endmodule

// File: rtl/twos_comp_word_sequencer.sv
// Word sequencer around the serial two's-complement core: capture, stream
// LSB-first, present the negated word. Optional ovf flag via TC_OVF_FLAG_EN.
module twos_comp_word_sequencer
  import twos_comp_pkg::*;
  #(parameter int WIDTH = DEFAULT_WIDTH)
  (
  input logic                        t_clock,
  input logic                        r_n,
  twos_comp_word_sequencer_if.slave  bus
);

  localparam int            CW   = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    count_q, count_d;
  logic             in_ready_q, out_valid_q, busy_q;
  logic             core_clr, core_x, core_y;

  // The core is cleared on the acceptance edge and sees zeros outside SHIFT.
  assign core_clr = (state_q == IDLE) && bus.in_valid;
  assign core_x   = (state_q == SHIFT) ? shift_q[0] : 1'b0;

  serial_twos_comp_bit u_core (
    .t_clock (t_clock),
    .r_n     (r_n),
    .clr     (core_clr),
    .x       (core_x),
    .y       (core_y)
  );

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    result_d = result_q;
    count_d  = count_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          shift_d = bus.in_data;
          count_d = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift_d  = shift_q >> 1;
        result_d = {core_y, result_q[WIDTH-1:1]};
        count_d  = count_q + 1'b1;
        if (count_q == LAST) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so they change only on edges.
  always_ff @(posedge t_clock or negedge r_n) begin
    if (!r_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      result_q    <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      result_q    <= result_d;
      count_q     <= count_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = result_q;
  assign bus.busy      = busy_q;

`ifdef TC_OVF_FLAG_EN
  // Only the most-negative word negates to itself; flag it from capture to handshake.
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if ((state_q == IDLE) && bus.in_valid)        ovf_d = (bus.in_data == MOST_NEG);
    else if ((state_q == DONE) && bus.out_ready)  ovf_d = 1'b0;
  end

  always_ff @(posedge t_clock or negedge r_n) begin
    if (!r_n) ovf_q <= 1'b0;
    else      ovf_q <= ovf_d;
  end

  assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_twos_comp_word_sequencer.sv
// Scoreboard bench for twos_comp_word_sequencer at WIDTH=8 and WIDTH=5;
// ovf checks are compiled in only when TC_OVF_FLAG_EN is defined.
`timescale 1ns/1ps
module tb_twos_comp_word_sequencer;

  typedef struct packed {
    logic [7:0] data;
    logic       ovf;
  } exp_t;

  logic t_clock = 1'b0;
  logic r_n     = 1'b1;
  int   compared   = 0;
  int   mismatched = 0;
  int   cycle      = 0;
  bit   rand_done  = 1'b0;
  exp_t exp8_q[$];
  exp_t exp5_q[$];
  exp_t e8, e5;

  twos_comp_word_sequencer_if #(.WIDTH(8)) bus8();
  twos_comp_word_sequencer_if #(.WIDTH(5)) bus5();

  twos_comp_word_sequencer #(.WIDTH(8)) dut8 (.t_clock(t_clock), .r_n(r_n), .bus(bus8));
  twos_comp_word_sequencer #(.WIDTH(5)) dut5 (.t_clock(t_clock), .r_n(r_n), .bus(bus5));

  always #5 t_clock = ~t_clock;

  always @(posedge t_clock) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic reportTimeout(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: wait bound expired at cycle %0d", name, cycle);
  endtask

  // Monitors: a handshake is visible at the negedge before the accepting posedge
  always @(negedge t_clock) begin
    if (r_n && bus8.out_valid === 1'b1 && bus8.out_ready === 1'b1) begin
      if (exp8_q.size() == 0) begin
        reportTimeout("w8 result with empty scoreboard");
      end else begin
        e8 = exp8_q.pop_front();
        checkOutput("w8 out_data", {24'd0, bus8.out_data}, {24'd0, e8.data});
`ifdef TC_OVF_FLAG_EN
        checkOutput("w8 ovf", {31'd0, bus8.ovf}, {31'd0, e8.ovf});
`endif
      end
    end
  end

  always @(negedge t_clock) begin
    if (r_n && bus5.out_valid === 1'b1 && bus5.out_ready === 1'b1) begin
      if (exp5_q.size() == 0) begin
        reportTimeout("w5 result with empty scoreboard");
      end else begin
        e5 = exp5_q.pop_front();
        checkOutput("w5 out_data", {27'd0, bus5.out_data}, {24'd0, e5.data});
`ifdef TC_OVF_FLAG_EN
        checkOutput("w5 ovf", {31'd0, bus5.ovf}, {31'd0, e5.ovf});
`endif
      end
    end
  end

  task automatic waitReady8(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge t_clock);
      if (bus8.in_ready === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) reportTimeout("w8 in_ready");
  endtask

  task automatic waitReady5(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge t_clock);
      if (bus5.in_ready === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) reportTimeout("w5 in_ready");
  endtask

  // Presents one word to the 8-bit instance; it is accepted at the next posedge
  task automatic applyStimulus(input logic [7:0] data, input logic [7:0] expected,
                               input logic exp_ovf, input bit track);
    bit ok;
    waitReady8(ok);
    if (!ok) return;
    bus8.in_valid = 1'b1;
    bus8.in_data  = data;
    if (track) exp8_q.push_back('{data: expected, ovf: exp_ovf});
    @(posedge t_clock);
    #1;
    bus8.in_valid = 1'b0;
  endtask

  task automatic drainAll();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge t_clock);
      if (exp8_q.size() == 0 && exp5_q.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) reportTimeout("scoreboard drain");
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit          ok;
    int          t1, t2;
    logic [7:0]  d8;
    logic [4:0]  d5;

    bus8.in_valid = 1'b0; bus8.in_data = '0; bus8.out_ready = 1'b0;
    bus5.in_valid = 1'b0; bus5.in_data = '0; bus5.out_ready = 1'b0;

    // Reset state
    #2 r_n = 1'b0;
    repeat (2) @(posedge t_clock);
    @(negedge t_clock);
    checkOutput("reset in_ready",  {31'd0, bus8.in_ready},  32'd1);
    checkOutput("reset out_valid", {31'd0, bus8.out_valid}, 32'd0);
    checkOutput("reset out_data",  {24'd0, bus8.out_data},  32'd0);
    checkOutput("reset busy",      {31'd0, bus8.busy},      32'd0);
    checkOutput("reset w5 ready",  {31'd0, bus5.in_ready},  32'd1);
`ifdef TC_OVF_FLAG_EN
    checkOutput("reset ovf",       {31'd0, bus8.ovf},       32'd0);
`endif
    r_n = 1'b1;

    // Test 1: 0x05 -> 0xFB, latency and in_ready low through SHIFT
    $display("[TB] test 1: latency");
    bus8.out_ready = 1'b1;
    applyStimulus(8'h05, 8'hFB, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge t_clock);
      checkOutput($sformatf("t1 in_ready shift %0d", i),  {31'd0, bus8.in_ready},  32'd0);
      checkOutput($sformatf("t1 out_valid shift %0d", i), {31'd0, bus8.out_valid}, 32'd0);
      checkOutput($sformatf("t1 busy shift %0d", i),      {31'd0, bus8.busy},      32'd1);
    end
    @(negedge t_clock);
    checkOutput("t1 out_valid after T+8", {31'd0, bus8.out_valid}, 32'd1);
    drainAll();

    // Test 2: zero, all-ones, most-negative
    $display("[TB] test 2: boundary words");
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b1);
    applyStimulus(8'hFF, 8'h01, 1'b0, 1'b1);
    applyStimulus(8'h80, 8'h80, 1'b1, 1'b1);
    applyStimulus(8'h7F, 8'h81, 1'b0, 1'b1);
    drainAll();

    // Test 3: back-pressure holds the result and blocks new captures
    $display("[TB] test 3: back-pressure");
    @(posedge t_clock); #1;
    bus8.out_ready = 1'b0;
    applyStimulus(8'h3C, 8'hC4, 1'b0, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge t_clock);
      if (bus8.out_valid === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) reportTimeout("t3 out_valid");
    bus8.in_valid = 1'b1;
    bus8.in_data  = 8'h11;
    for (int i = 0; i < 5; i++) begin
      @(negedge t_clock);
      checkOutput($sformatf("t3 out_valid hold %0d", i), {31'd0, bus8.out_valid}, 32'd1);
      checkOutput($sformatf("t3 out_data hold %0d", i),  {24'd0, bus8.out_data},  32'hC4);
      checkOutput($sformatf("t3 in_ready hold %0d", i),  {31'd0, bus8.in_ready},  32'd0);
    end
    @(posedge t_clock); #1;
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b1;
    drainAll();
    @(negedge t_clock);
    checkOutput("t3 no capture busy", {31'd0, bus8.busy}, 32'd0);

    // Test 4: reset in the third SHIFT cycle, then a clean word
    $display("[TB] test 4: reset mid-shift");
    applyStimulus(8'hA5, 8'h00, 1'b0, 1'b0);
    repeat (2) @(posedge t_clock);
    #3 r_n = 1'b0;
    #1;
    checkOutput("t4 reset in_ready",  {31'd0, bus8.in_ready},  32'd1);
    checkOutput("t4 reset out_valid", {31'd0, bus8.out_valid}, 32'd0);
    checkOutput("t4 reset busy",      {31'd0, bus8.busy},      32'd0);
    checkOutput("t4 reset out_data",  {24'd0, bus8.out_data},  32'd0);
    @(negedge t_clock);
    r_n = 1'b1;
    applyStimulus(8'h01, 8'hFF, 1'b0, 1'b1);
    drainAll();

    // Test 5: in_valid held high across two words
    $display("[TB] test 5: back-to-back");
    waitReady8(ok);
    bus8.in_valid = 1'b1;
    bus8.in_data  = 8'h01;
    exp8_q.push_back('{data: 8'hFF, ovf: 1'b0});
    t1 = cycle;
    @(posedge t_clock); #1;
    bus8.in_data = 8'h02;
    waitReady8(ok);
    t2 = cycle;
    exp8_q.push_back('{data: 8'hFE, ovf: 1'b0});
    @(posedge t_clock); #1;
    bus8.in_valid = 1'b0;
    checkOutput("t5 acceptance spacing", t2 - t1, 32'd10);
    drainAll();

    // Test 6: random words on both widths with random out_ready
    $display("[TB] test 6: random");
    fork
      begin
        fork
          begin
            for (int n = 0; n < 500; n++) begin
              bit rdy;
              waitReady8(rdy);
              if (!rdy) break;
              d8 = 8'($urandom);
              bus8.in_valid = 1'b1;
              bus8.in_data  = d8;
              exp8_q.push_back('{data: 8'(8'd0 - d8), ovf: (d8 == 8'h80)});
              @(posedge t_clock); #1;
              bus8.in_valid = 1'b0;
              repeat ($urandom_range(0, 2)) @(posedge t_clock);
            end
          end
          begin
            for (int n = 0; n < 500; n++) begin
              bit rdy;
              waitReady5(rdy);
              if (!rdy) break;
              d5 = 5'($urandom_range(0, 31));
              bus5.in_valid = 1'b1;
              bus5.in_data  = d5;
              exp5_q.push_back('{data: {3'd0, 5'(5'd0 - d5)}, ovf: (d5 == 5'h10)});
              @(posedge t_clock); #1;
              bus5.in_valid = 1'b0;
              repeat ($urandom_range(0, 2)) @(posedge t_clock);
            end
          end
        join
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge t_clock); #1;
          if (!rand_done) begin
            bus8.out_ready = 1'($urandom_range(0, 1));
            bus5.out_ready = 1'($urandom_range(0, 1));
          end
        end
      end
    join
    @(posedge t_clock); #1;
    bus8.out_ready = 1'b1;
    bus5.out_ready = 1'b1;
    drainAll();

    checkOutput("w8 scoreboard empty", exp8_q.size(), 32'd0);
    checkOutput("w5 scoreboard empty", exp5_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
